// File: rtl/hi_wb_initiator.sv
// hi_wb_initiator: Wishbone classic initiator that converts a valid/ready
// command stream into single 32-bit bus cycles and returns each result on a
// valid/ready response stream. One transaction is outstanding at a time and
// a bounded ack timeout guarantees forward progress.
// Optional feature macro: HI_WB_INITIATOR_STATS_EN adds the stat_txn/stat_tmo
// transaction and timeout counters.
module hi_wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
`ifdef HI_WB_INITIATOR_STATS_EN
  ,
  output logic [15:0] stat_txn,
  output logic [15:0] stat_tmo
`endif
);

  localparam int unsigned TIMER_W = 16;
  localparam bit          TMO_EN  = (TIMEOUT_CYCLES != 0);
  // Timer value seen during the last cycle stb may stay high without ack.
  localparam logic [TIMER_W-1:0] TMO_LAST =
    TMO_EN ? TIMER_W'(TIMEOUT_CYCLES - 1) : TIMER_W'(0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_dat_q,   rsp_dat_d;
  logic               rsp_err_q,   rsp_err_d;
  logic               cyc_q,       cyc_d;
  logic               stb_q,       stb_d;
  logic               we_q,        we_d;
  logic [3:0]         sel_q,       sel_d;
  logic [31:0]        adr_q,       adr_d;
  logic [31:0]        dat_q,       dat_d;
  logic [TIMER_W-1:0] timer_q,     timer_d;
`ifdef HI_WB_INITIATOR_STATS_EN
  logic [15:0]        stat_txn_q,  stat_txn_d;
  logic [15:0]        stat_tmo_q,  stat_tmo_d;
`endif

  logic cmd_fire_c;
  logic ack_hit_c;
  logic tmo_hit_c;
  logic rsp_fire_c;

  // Handshake and bus-completion events for the current cycle.
  always_comb begin
    cmd_fire_c = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
    ack_hit_c  = (state_q == S_BUS) && wbm_ack_i;
    tmo_hit_c  = (state_q == S_BUS) && !wbm_ack_i && TMO_EN && (timer_q >= TMO_LAST);
    rsp_fire_c = (state_q == S_RESP) && rsp_valid_q && rsp_ready;
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack in the timeout cycle takes priority.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_fire_c) state_d = S_BUS;
      S_BUS:  if (ack_hit_c || tmo_hit_c) state_d = S_RESP;
      S_RESP: if (rsp_fire_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values, all registered below.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    cyc_d       = (state_d == S_BUS);
    stb_d       = (state_d == S_BUS);
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    timer_d     = timer_q;
`ifdef HI_WB_INITIATOR_STATS_EN
    stat_txn_d  = stat_txn_q;
    stat_tmo_d  = stat_tmo_q;
`endif

    if (cmd_fire_c) begin
      we_d    = cmd_we;
      sel_d   = cmd_sel;
      adr_d   = cmd_adr;
      dat_d   = cmd_dat;
      timer_d = '0;
    end

    if ((state_q == S_BUS) && stb_q && (timer_q != {TIMER_W{1'b1}})) begin
      timer_d = timer_q + TIMER_W'(1);
    end

    if (ack_hit_c) begin
      rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
      rsp_err_d = 1'b0;
    end else if (tmo_hit_c) begin
      rsp_dat_d = ERR_DATA;
      rsp_err_d = 1'b1;
    end

`ifdef HI_WB_INITIATOR_STATS_EN
    if (ack_hit_c || tmo_hit_c) stat_txn_d = stat_txn_q + 16'd1;
    if (tmo_hit_c)              stat_tmo_d = stat_tmo_q + 16'd1;
`endif
  end

  // Output and datapath registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      timer_q     <= '0;
`ifdef HI_WB_INITIATOR_STATS_EN
      stat_txn_q  <= '0;
      stat_tmo_q  <= '0;
`endif
    end else begin
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      timer_q     <= timer_d;
`ifdef HI_WB_INITIATOR_STATS_EN
      stat_txn_q  <= stat_txn_d;
      stat_tmo_q  <= stat_tmo_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
`ifdef HI_WB_INITIATOR_STATS_EN
  assign stat_txn  = stat_txn_q;
  assign stat_tmo  = stat_tmo_q;
`endif

endmodule

// File: tb/tb_hi_wb_initiator.sv
// Bench for hi_wb_initiator: directed register-map transactions followed by
// randomized commands, checked against a transaction-level reference model.
module tb_hi_wb_initiator;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
`ifdef HI_WB_INITIATOR_STATS_EN
  logic [15:0] stat_txn, stat_tmo;
`endif

  always #5 clk = ~clk;

  hi_wb_initiator #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
`ifdef HI_WB_INITIATOR_STATS_EN
    , .stat_txn(stat_txn), .stat_tmo(stat_tmo)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_txn = 0;
  int exp_tmo = 0;

  // Slave register contents and the reference model's view of them.
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int   ack_at    = 0;   // stb cycle (1-based) in which the slave acks; 0 = never
  int   stb_cnt   = 0;
  logic force_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Register-file slave: acks in the programmed stb cycle, noise otherwise.
  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1) begin
        stb_cnt++;
        if (ack_at != 0 && stb_cnt == ack_at) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = $urandom;
          if (wbm_we_o) begin
            logic [31:0] mask;
            mask = {{8{wbm_sel_o[3]}}, {8{wbm_sel_o[2]}}, {8{wbm_sel_o[1]}}, {8{wbm_sel_o[0]}}};
            if (wbm_adr_o >= 32'h100)
              slv_mem[wbm_adr_o] = (slv_rd(wbm_adr_o) & ~mask) | (wbm_dat_o & mask);
          end else begin
            wbm_dat_i = slv_rd(wbm_adr_o);
          end
        end else begin
          wbm_ack_i = 1'b0;
          wbm_dat_i = $urandom;
        end
      end else begin
        stb_cnt   = 0;
        wbm_ack_i = force_ack;
        wbm_dat_i = $urandom;
      end
    end
  end

  // One command through the DUT, with the expected outcome computed up front.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack, input int hold);
    bit          tmo;
    int          k_exp;
    int          cnt;
    int          guard;
    logic [31:0] exp_dat;

    tmo   = (ack == 0) || (ack > int'(TMO));
    k_exp = tmo ? int'(TMO) : ack;
    if (tmo) begin
      exp_dat = ERR;
    end else if (we) begin
      exp_dat = 32'h0;
      if (adr >= 32'h100) begin
        logic [31:0] v;
        v = ref_rd(adr);
        for (int b = 0; b < 4; b++)
          if (sel[b]) v[b*8 +: 8] = dat[b*8 +: 8];
        ref_mem[adr] = v;
      end
    end else begin
      exp_dat = ref_rd(adr);
    end
    exp_txn++;
    if (tmo) exp_tmo++;

    ack_at = ack;
    guard  = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);

    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);

    check("stb_latency", 32'({wbm_cyc_o, wbm_stb_o}), 32'h3);
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    check("wb_adr", wbm_adr_o, adr);
    check("wb_we_sel", 32'({wbm_we_o, wbm_sel_o}), 32'({we, sel}));
    if (we) check("wb_dat", wbm_dat_o, dat);

    cnt = 0;
    while (wbm_stb_o === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("stb_cycles", 32'(cnt), 32'(k_exp));
    check("cyc_low", 32'(wbm_cyc_o), 32'd0);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_err", 32'(rsp_err), 32'(tmo));
    check("rsp_dat", rsp_dat, exp_dat);
    check("adr_kept", wbm_adr_o, adr);

    if (hold > 0) begin
      cmd_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        check("hold_no_cyc", 32'(wbm_cyc_o), 32'd0);
        check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        check("hold_rsp_dat", rsp_dat, exp_dat);
      end
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_done", 32'(rsp_valid), 32'd0);
    check("cmd_ready_after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        we;
    logic [31:0] adr;

    slv_mem[32'h0] = 32'h4849_4348; ref_mem[32'h0] = 32'h4849_4348;
    slv_mem[32'h4] = 32'h0000_0001; ref_mem[32'h4] = 32'h0000_0001;

    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_bus_ctl", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 32'd0);
    check("rst_bus_adr", wbm_adr_o, 32'd0);
    check("rst_bus_dat", wbm_dat_o, 32'd0);
    wb_rst_i = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Register map reads, control write, and an unacknowledged access.
    do_txn(1'b0, 32'h0,   32'h0, 4'hF, 2, 0);
    do_txn(1'b0, 32'h4,   32'h0, 4'hF, 1, 0);
    do_txn(1'b1, 32'h100, 32'h1, 4'hF, 3, 0);
    check("ctrl_enable", 32'(slv_rd(32'h100) & 32'h1), 32'd1);
    do_txn(1'b0, 32'h108, 32'h0, 4'hF, 0, 0);
`ifdef HI_WB_INITIATOR_STATS_EN
    check("stat_txn_4", 32'(stat_txn), 32'd4);
    check("stat_tmo_1", 32'(stat_tmo), 32'd1);
`endif
    do_txn(1'b0, 32'h0,   32'h0, 4'hF, 1, 0);

    // Ack in the timeout cycle wins; one cycle later it is too late.
    do_txn(1'b0, 32'h4,   32'h0, 4'hF, 8, 0);
    do_txn(1'b0, 32'h4,   32'h0, 4'hF, 9, 0);

    // Back-pressured response.
    do_txn(1'b1, 32'h104, 32'hA5A5_5A5A, 4'b0101, 2, 5);
    do_txn(1'b0, 32'h104, 32'h0, 4'hF, 4, 0);

    // Reset pulse while the bus cycle is pending, then a stray ack.
    ack_at = 0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_sel = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_in_bus", 32'(wbm_stb_o), 32'd1);
    wb_rst_i  = 1'b1;
    force_ack = 1'b1;
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    check("midrst_bus", 32'({wbm_cyc_o, wbm_stb_o, rsp_valid}), 32'd0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    check("late_ack_cyc", 32'(wbm_cyc_o), 32'd0);
    check("late_ack_rsp", 32'(rsp_valid), 32'd0);
    check("late_ack_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("late_ack_idle", 32'({wbm_cyc_o, rsp_valid}), 32'd0);
`ifdef HI_WB_INITIATOR_STATS_EN
    // Counters were cleared by the reset pulse.
    exp_txn = 0;
    exp_tmo = 0;
`endif
    do_txn(1'b0, 32'h0, 32'h0, 4'hF, 2, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom);
      if (we || ($urandom % 3) != 0) adr = 32'h100 + 32'(4 * ($urandom % 16));
      else                           adr = 32'(4 * ($urandom % 2));
      do_txn(we, adr, $urandom, 4'($urandom), int'($urandom_range(0, 10)),
             int'($urandom_range(0, 3)));
    end

`ifdef HI_WB_INITIATOR_STATS_EN
    check("stat_txn_end", 32'(stat_txn), 32'(exp_txn));
    check("stat_tmo_end", 32'(stat_tmo), 32'(exp_tmo));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
